ysyx_22040931_mem_bridge: RTL and testbench
===========================================

# ysyx_22040931_mem_bridge

Memory-side bridge directly downstream of the core's MEM stage. It replaces the combinational load/store path with a registered, single-outstanding valid/ready bus transaction. It turns the core's request (enable, write, size, address, store data) into a doubleword-aligned bus request with byte mask and lane-shifted write data. It stalls the core until the response returns and presents the raw read doubleword for the MEM stage's own extraction.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width; fixed at 64, so the mask is 8 bits

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- mem_ena  in  1  core memory request
- mem_wr  in  1  1 = store, 0 = load
- memop  in  2  size: 00 B, 01 H, 10 W, 11 D
- mem_addr  in  ADDR_W  byte address
- mem_stor_data  in  64  store data, right-aligned
- mem_stall  out  1  hold the core pipeline
- mem_rdata  out  64  raw aligned doubleword from the last load
- mem_err  out  1  one-cycle pulse: misaligned access or bus error
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted
- bus_req_addr  out  ADDR_W  {mem_addr[ADDR_W-1:3], 3'b0}
- bus_req_wr  out  1  store flag
- bus_req_wdata  out  64  mem_stor_data << (8*addr[2:0])
- bus_req_wmask  out  8  byte enables; 0 for loads
- bus_rsp_valid  in  1  response / write acknowledge
- bus_rsp_rdata  in  64  read doubleword
- bus_rsp_err  in  1  response error

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- **IDLE**
  - If mem_ena is high and the access is aligned: latch address, size, wr, wdata and wmask; go to REQ. mem_stall is high combinationally in this same cycle.
  - If mem_ena is high and the access is misaligned (H with addr[0]=1; W with addr[1:0]≠0; D with addr[2:0]≠0): no bus request is issued, mem_err pulses, mem_stall stays low, and the FSM stays in IDLE.
- **REQ**: bus_req_valid=1 with the latched fields held stable. When bus_req_ready=1, go to RESP.
- **RESP**: wait for bus_rsp_valid. On it, capture rdata (loads only) and err, then go to DONE.
- **DONE**: one cycle.
  - mem_stall=0, so the core advances on the next edge.
  - mem_rdata is valid.
  - mem_err is set if bus_rsp_err was captured.
  - Next state is IDLE.
- Byte masks:
  - B: 8'b1 << a
  - H: 8'b11 << a
  - W: 8'hF << a
  - D: 8'hFF
  - Here a = addr[2:0]. Loads drive wmask=0.
- Stores also wait for bus_rsp_valid as a write acknowledge. Their mem_rdata is unchanged.
- bus_rsp_valid is ignored in IDLE, REQ and DONE.
- mem_rdata holds its value until the next load completes.

## Timing
- Reset values:
  - state IDLE
  - bus_req_valid 0, bus_req_wr 0, bus_req_addr 0, bus_req_wdata 0, bus_req_wmask 0
  - mem_rdata 0, mem_err 0
  - mem_stall is combinational: 0 in IDLE with mem_ena low.
- mem_stall = (IDLE & mem_ena & aligned) | REQ | RESP.
- Minimum stall is 3 cycles. With ready=1 in the first REQ cycle and rsp_valid in the first RESP cycle:
  - cycle 0: IDLE
  - cycle 1: REQ
  - cycle 2: RESP
  - cycle 3: DONE, stall low
- A response cannot complete in the same cycle as request acceptance.
- The core holds all mem_* inputs stable while mem_stall=1. The bridge uses only its latched copies after IDLE.
- bus_req_valid never drops before ready, and the request fields never change while valid is high.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and bus_req_valid drops asynchronously. A stale response after reset release is ignored in IDLE.
- Back-to-back requests: the next request is seen in the IDLE cycle that follows DONE, giving 1 bubble cycle.

## Structure
- Shared package: size encodings SIZE_B/H/W/D and the FSM state enum. The state enum is 2-bit and encodes IDLE=0, REQ=1, RESP=2, DONE=3.
- Sub-module ysyx_22040931_mem_lane (combinational):
  - inputs: memop, addr[2:0], wr, store data
  - outputs: wmask, shifted wdata, misaligned flag
- Top-level wrapper: FSM and registers only.

## Test plan
- **SD, aligned, immediate ready.** Stimulus: SD addr 0x8000_0010, data 0x1122334455667788, ready=1, rsp_valid one cycle later. Required: bus_req_addr 0x8000_0010, wmask 0xFF, wdata unchanged, stall high for exactly 3 cycles.
- **SB at offset 5.** Stimulus: SB addr 0x8000_0005, data 0xAB. Required: addr 0x8000_0000, wmask 0x20, wdata 0x0000AB0000000000.
- **LW at offset 4 with backpressure.** Stimulus: LW addr 0x8000_0004, ready low for 4 cycles, rsp_rdata 0xDEADBEEF_01234567. Required: valid held 5 cycles with fields stable, wmask 0, and mem_rdata = 0xDEADBEEF_01234567 in DONE.
- **Misaligned LH.** Stimulus: LH addr 0x8000_0003. Required: no bus_req_valid, mem_err 1 for one cycle, mem_stall 0.
- **Bus error.** Stimulus: LD with bus_rsp_err=1. Required: mem_err pulse in DONE, mem_rdata still updated.
- **Reset mid-transaction.** Stimulus: reset low during RESP, then a stray rsp_valid after release. Required: all outputs at reset values, FSM stays in IDLE, mem_rdata stays 0.

Source files
------------

// File: rtl/ysyx_22040931_mem_bridge_pkg.sv
// ysyx_22040931_mem_bridge_pkg: shared size encodings and bridge FSM states
package ysyx_22040931_mem_bridge_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/ysyx_22040931_mem_lane.sv
// ysyx_22040931_mem_lane: memop/addr[2:0]/wr/stor_data -> byte mask, lane-shifted wdata, misaligned flag
module ysyx_22040931_mem_lane
  import ysyx_22040931_mem_bridge_pkg::*;
(
  input  logic [1:0]  memop,
  input  logic [2:0]  addr,
  input  logic        wr,
  input  logic [63:0] stor_data,
  output logic [7:0]  wmask,
  output logic [63:0] wdata,
  output logic        misaligned
);
  logic [7:0] size_mask;
  always_comb begin
    size_mask  = memop == SIZE_B ? 8'h01 : memop == SIZE_H ? 8'h03 : memop == SIZE_W ? 8'h0F : 8'hFF;
    misaligned = memop == SIZE_H ? addr[0] : memop == SIZE_W ? |addr[1:0] : memop == SIZE_D ? |addr : 1'b0;
    wmask      = wr ? size_mask << addr : 8'h00;
    wdata      = stor_data << {addr, 3'b000};
  end
endmodule

// File: rtl/ysyx_22040931_mem_bridge.sv
// ysyx_22040931_mem_bridge: core mem_* request -> single-outstanding valid/ready bus transaction; stalls core, returns raw doubleword
module ysyx_22040931_mem_bridge
  import ysyx_22040931_mem_bridge_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mem_ena,
  input  logic                mem_wr,
  input  logic [1:0]          memop,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_stor_data,
  output logic                mem_stall,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_err,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic [ADDR_W-1:0]   bus_req_addr,
  output logic                bus_req_wr,
  output logic [DATA_W-1:0]   bus_req_wdata,
  output logic [DATA_W/8-1:0] bus_req_wmask,
  input  logic                bus_rsp_valid,
  input  logic [DATA_W-1:0]   bus_rsp_rdata,
  input  logic                bus_rsp_err
);
  state_t state, state_nxt;
  logic err_q, start, misaligned;
  logic [DATA_W/8-1:0] lane_mask;
  logic [DATA_W-1:0] lane_wdata;
  ysyx_22040931_mem_lane u_lane (
    .memop     (memop),
    .addr      (mem_addr[2:0]),
    .wr        (mem_wr),
    .stor_data (mem_stor_data),
    .wmask     (lane_mask),
    .wdata     (lane_wdata),
    .misaligned(misaligned)
  );
  always_comb begin
    state_nxt = state;
    start = state == IDLE && mem_ena && !misaligned;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ:  if (bus_req_ready) state_nxt = RESP;
      RESP: if (bus_rsp_valid) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    mem_stall     = start || state == REQ || state == RESP;
    mem_err       = (state == IDLE && mem_ena && misaligned) || (state == DONE && err_q);
    bus_req_valid = state == REQ;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      err_q         <= 1'b0;
      mem_rdata     <= '0;
      bus_req_addr  <= '0;
      bus_req_wr    <= 1'b0;
      bus_req_wdata <= '0;
      bus_req_wmask <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        bus_req_addr  <= {mem_addr[ADDR_W-1:3], 3'b000};
        bus_req_wr    <= mem_wr;
        bus_req_wdata <= lane_wdata;
        bus_req_wmask <= lane_mask;
      end
      if (state == RESP && bus_rsp_valid) begin
        err_q <= bus_rsp_err;
        if (!bus_req_wr) mem_rdata <= bus_rsp_rdata;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22040931_mem_bridge.sv
// tb_ysyx_22040931_mem_bridge: directed plus randomized transactions checked against an arithmetic bus model
module tb_ysyx_22040931_mem_bridge;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic mem_ena = 1'b0, mem_wr = 1'b0;
  logic [1:0] memop = 2'b00;
  logic [63:0] mem_addr = '0, mem_stor_data = '0;
  logic mem_stall, mem_err, bus_req_valid, bus_req_wr;
  logic [63:0] mem_rdata, bus_req_addr, bus_req_wdata;
  logic [7:0] bus_req_wmask;
  logic bus_req_ready = 1'b0, bus_rsp_valid = 1'b0, bus_rsp_err = 1'b0;
  logic [63:0] bus_rsp_rdata = '0;
  int n_asrt = 0, n_fail = 0;
  logic [63:0] exp_rdata = '0;

  ysyx_22040931_mem_bridge dut (
    .clock(clock), .reset(reset),
    .mem_ena(mem_ena), .mem_wr(mem_wr), .memop(memop), .mem_addr(mem_addr), .mem_stor_data(mem_stor_data),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
    .bus_req_wr(bus_req_wr), .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valid"}, bus_req_valid, 0);
    chk({tag, "_wr"}, bus_req_wr, 0);
    chk({tag, "_addr"}, bus_req_addr, 0);
    chk({tag, "_wdata"}, bus_req_wdata, 0);
    chk({tag, "_wmask"}, bus_req_wmask, 0);
    chk({tag, "_rdata"}, mem_rdata, 0);
    chk({tag, "_err"}, mem_err, 0);
    chk({tag, "_stall"}, mem_stall, 0);
  endtask

  // Starts at #1 after a rising edge with the bridge idle; ends the same way.
  task automatic txn(input logic wr, input logic [1:0] op, input logic [63:0] addr, input logic [63:0] data,
                     input int rd, input int sd, input logic [63:0] rdata, input logic err);
    int a, bytes, stalls;
    logic mis;
    logic [7:0] em;
    logic [63:0] ew, ea;
    a = int'(addr[2:0]);
    bytes = 1 << op;
    stalls = 0;
    mis = (a % bytes) != 0;
    em = wr ? 8'(((1 << bytes) - 1) << a) : 8'h00;
    ew = data << (8 * a);
    ea = addr - 64'(a);
    mem_ena = 1'b1; mem_wr = wr; memop = op; mem_addr = addr; mem_stor_data = data;
    @(negedge clock);
    chk("idle_stall", mem_stall, !mis);
    chk("idle_err", mem_err, mis);
    chk("idle_valid", bus_req_valid, 0);
    if (mem_stall) stalls++;
    @(posedge clock); #1;
    if (mis) begin
      mem_ena = 1'b0;
      chk("mis_no_req", bus_req_valid, 0);
      @(negedge clock);
      chk("mis_still_idle", bus_req_valid, 0);
      chk("mis_err_pulse", mem_err, 0);
      @(posedge clock); #1;
      return;
    end
    for (int k = 0; k <= rd; k++) begin
      bus_req_ready = (k == rd);
      bus_rsp_valid = 1'($urandom_range(0, 1));
      bus_rsp_rdata = {$urandom, $urandom};
      @(negedge clock);
      chk("req_valid", bus_req_valid, 1);
      chk("req_addr", bus_req_addr, ea);
      chk("req_wr", bus_req_wr, wr);
      chk("req_wdata", bus_req_wdata, ew);
      chk("req_wmask", bus_req_wmask, em);
      chk("req_err", mem_err, 0);
      if (mem_stall) stalls++;
      @(posedge clock); #1;
    end
    bus_req_ready = 1'b0;
    for (int k = 0; k <= sd; k++) begin
      bus_rsp_valid = (k == sd);
      bus_rsp_rdata = (k == sd) ? rdata : {$urandom, $urandom};
      bus_rsp_err = (k == sd) ? err : 1'b0;
      @(negedge clock);
      chk("resp_valid", bus_req_valid, 0);
      chk("resp_err", mem_err, 0);
      if (mem_stall) stalls++;
      @(posedge clock); #1;
    end
    bus_rsp_valid = 1'b1;
    bus_rsp_err = 1'b1;
    bus_rsp_rdata = ~rdata;
    if (!wr) exp_rdata = rdata;
    @(negedge clock);
    chk("done_stall", mem_stall, 0);
    chk("done_err", mem_err, err);
    chk("done_rdata", mem_rdata, exp_rdata);
    chk("stall_cycles", 64'(stalls), 64'(3 + rd + sd));
    @(posedge clock); #1;
    mem_ena = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_err = 1'b0;
  endtask

  initial begin
    @(negedge clock);
    chk_reset_values("rst");
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    txn(1'b1, 2'b11, 64'h8000_0010, 64'h1122_3344_5566_7788, 0, 0, 64'h0, 1'b0);
    txn(1'b1, 2'b00, 64'h8000_0005, 64'hAB, 0, 0, 64'h0, 1'b0);
    txn(1'b0, 2'b10, 64'h8000_0004, 64'h5555_AAAA_5555_AAAA, 4, 0, 64'hDEAD_BEEF_0123_4567, 1'b0);
    txn(1'b0, 2'b01, 64'h8000_0003, 64'h0, 0, 0, 64'h0, 1'b0);
    txn(1'b0, 2'b11, 64'h8000_0008, 64'h0, 0, 1, 64'hCAFE_F00D_1234_5678, 1'b1);
    txn(1'b1, 2'b01, 64'h8000_0006, 64'hFFFF_FFFF_FFFF_BEEF, 1, 2, 64'h0, 1'b0);
    for (int i = 0; i < 40; i++)
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 64'h8000_0000 + 64'($urandom_range(0, 63)),
          {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom},
          $urandom_range(0, 7) == 0);
    // Reset while waiting for the response, then a stray response after release.
    mem_ena = 1'b1; mem_wr = 1'b0; memop = 2'b11; mem_addr = 64'h8000_0020; mem_stor_data = 64'h0;
    @(posedge clock); #1;
    bus_req_ready = 1'b1;
    @(posedge clock); #1;
    bus_req_ready = 1'b0;
    #2;
    reset = 1'b0;
    mem_ena = 1'b0;
    #1;
    chk_reset_values("midrst");
    @(posedge clock); #1;
    reset = 1'b1;
    exp_rdata = '0;
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    @(negedge clock);
    chk("stray_valid", bus_req_valid, 0);
    chk("stray_stall", mem_stall, 0);
    @(posedge clock); #1;
    bus_rsp_valid = 1'b0;
    @(negedge clock);
    chk("stray_rdata", mem_rdata, exp_rdata);
    chk("stray_err", mem_err, 0);
    chk("stray_still_idle", bus_req_valid, 0);
    @(posedge clock); #1;
    txn(1'b0, 2'b00, 64'h8000_0031, 64'h0, 0, 0, 64'h0102_0304_0506_0708, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
